pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the simple RISC-V datapath, attached to the shared tri-state data bus. It holds the current PC and supports sequential advance (+4, optionally +2 for compressed code), absolute and PC-relative loads from the bus, and driving the PC or the link address onto the bus. A small return-address stack (RAS) accelerates call/return sequences. Control strobes come from the sequencer; all state updates on the rising clock edge.

## Interface
- XLEN, 32: PC and bus width.
- RESET_VECTOR, 0: PC value after reset; must be even.
- RAS_DEPTH, 4: return-address stack entries, power of two, ≥2.
- COMPRESSED, 0: 1 enables +2 step and 2-byte-aligned targets.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd  in  1  drive PC onto bus.
- rd_link  in  1  drive PC+4 onto bus.
- wr  in  1  load PC from bus (absolute).
- rel  in  1  PC <= PC + bus (two's-complement offset).
- inc  in  1  PC <= PC + 4.
- inc_half  in  1  PC <= PC + 2 (ignored when COMPRESSED=0).
- push  in  1  qualifier: push PC+4 to RAS in the same cycle.
- pop  in  1  PC <= RAS top; pop.
- clr_err  in  1  clear sticky error flags.
- bus  inout  XLEN  shared data bus.
- pc_out  out  XLEN  current PC (always valid).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- err_misalign  out  1  sticky: misaligned target loaded.
- err_underflow  out  1  sticky: pop on empty RAS.

## Operation
- PC update priority, one source per cycle: pop > wr > rel > inc > inc_half; lower-priority strobes in the same cycle are ignored. No strobe: PC holds.
- Target alignment (wr, rel, pop): bit 0 always forced to 0. When COMPRESSED=0, bit 1 also forced to 0; if it was 1, err_misalign sets.
- Arithmetic modulo 2^XLEN; PC+4, PC+2, PC+offset wrap silently.
- Bus drive combinational: rd → PC; else rd_link → PC+4; else high-Z. rd wins if both asserted.
- RAS: circular buffer, top pointer plus saturating count (0..RAS_DEPTH).
  - push alone: entry at top+1 <= old PC+4; count++ saturating at RAS_DEPTH. Push when full overwrites the oldest entry (pointer wraps), ras_full stays 1.
  - pop alone, count>0: PC <= top entry (aligned); pointer--; count--.
  - pop, count=0: PC unchanged, RAS unchanged, err_underflow sets; lower-priority PC strobes still suppressed.
  - push with pop, count>0: PC <= top entry; top entry replaced by old PC+4; count unchanged (co-routine swap). With count=0: behaves as push alone plus err_underflow set, PC unchanged.
  - push is independent of which PC strobe wins; link value is always pre-update PC+4.
- err flags: set takes priority over clr_err in the same cycle.

## Timing
- Reset (async, immediate): PC = RESET_VECTOR, count = 0, pointer = 0, err_misalign = 0, err_underflow = 0; ras_empty = 1, ras_full = 0. RAS contents undefined. bus released when rd/rd_link low.
- All register updates at posedge clk; visible on pc_out/bus one cycle later (latency 1).
- wr/rel sample bus at the same edge; bus must be stable around that edge (may be driven by another block or by this one via rd for rel: PC <= 2·PC).
- ras_empty/ras_full/err flags are registered; reflect an operation the cycle after it.
- Reset asserted mid-operation aborts any update in progress; no partial RAS write.

## Test plan
- Reset with RESET_VECTOR=0x100, then inc ×3 → pc_out 0x10C; rd=1 → bus 0x10C; rd=0 → bus Z.
- Load/relative: bus=0x2000, wr → PC 0x2000; bus=0xFFFFFFF0, rel → PC 0x1FF0; COMPRESSED=0, bus=0x3002, wr → PC 0x3000, err_misalign=1; clr_err → 0.
- Call/return: PC 0x40, wr+push with bus=0x800 → PC 0x800, RAS top 0x44; pop → PC 0x44, ras_empty=1.
- RAS overflow: RAS_DEPTH=4, five pushes with links 0x4,0x8,0xC,0x10,0x14 → ras_full=1; four pops yield 0x14,0x10,0xC,0x8; fifth pop → PC unchanged, err_underflow=1.
- Simultaneous: inc+wr → wr wins; push+pop with top=0x44, PC=0x900 → PC 0x44, top 0x904, count unchanged; PC=0xFFFFFFFC, inc → 0x0.
- Async reset asserted between edges mid-sequence → pc_out = RESET_VECTOR immediately, ras_empty=1, flags 0.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Program-counter unit for the RISC-V datapath. Holds the PC and
//            supports sequential advance, absolute and PC-relative loads from
//            the shared tri-state bus, and a return-address stack (RAS).
//            The unit can drive either the PC or the link address (PC+4)
//            onto the bus.
// Ports    : clk, rst            clock, asynchronous active-high reset
//            rd, rd_link         drive PC / PC+4 onto bus (rd wins)
//            wr, rel             PC <= bus / PC <= PC + bus
//            inc, inc_half       PC <= PC + 4 / PC + 2 (COMPRESSED only)
//            push, pop           RAS push of PC+4 / PC <= RAS top
//            clr_err             clear sticky error flags
//            bus                 shared XLEN-bit tri-state data bus
//            pc_out              current PC
//            ras_empty, ras_full RAS occupancy flags
//            err_misalign        sticky misaligned-target flag
//            err_underflow       sticky pop-on-empty flag
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              COMPRESSED   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd,
  input  logic            rd_link,
  input  logic            wr,
  input  logic            rel,
  input  logic            inc,
  input  logic            inc_half,
  input  logic            push,
  input  logic            pop,
  input  logic            clr_err,
  inout  wire  [XLEN-1:0] bus,
  output logic [XLEN-1:0] pc_out,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            err_misalign,
  output logic            err_underflow
);

  localparam int                c_PTR_W = $clog2(RAS_DEPTH);
  localparam int                c_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RAS_DEPTH);
  localparam logic [XLEN-1:0]   c_FOUR  = XLEN'(4);
  localparam logic [XLEN-1:0]   c_TWO   = XLEN'(2);

  // State
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [c_PTR_W-1:0] ptr_q, ptr_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    ras_q [RAS_DEPTH];
  logic               mis_q, mis_d;
  logic               und_q, und_d;

  // Combinational helpers
  logic [XLEN-1:0]    w_link;
  logic [XLEN-1:0]    w_target;
  logic [XLEN-1:0]    w_aligned;
  logic               w_load;
  logic               w_misalign;
  logic               w_underflow;
  logic               w_pop_hit;
  logic [c_PTR_W-1:0] w_waddr;

  assign w_link      = pc_q + c_FOUR;
  assign w_pop_hit   = pop && (cnt_q != '0);
  assign w_underflow = pop && (cnt_q == '0);

  // Bit 0 is always cleared; bit 1 survives only with compressed code.
  assign w_aligned  = {w_target[XLEN-1:2],
                       (COMPRESSED != 0) ? w_target[1] : 1'b0,
                       1'b0};
  assign w_misalign = w_load && (COMPRESSED == 0) && w_target[1];

  // PC source selection, highest priority first. A pop on an empty stack
  // still owns the cycle, so lower strobes are suppressed and the PC holds.
  always_comb begin
    pc_d     = pc_q;
    w_target = '0;
    w_load   = 1'b0;
    if (pop) begin
      if (w_pop_hit) begin
        w_target = ras_q[ptr_q];
        w_load   = 1'b1;
      end
    end else if (wr) begin
      w_target = bus;
      w_load   = 1'b1;
    end else if (rel) begin
      w_target = pc_q + bus;
      w_load   = 1'b1;
    end else if (inc) begin
      pc_d = pc_q + c_FOUR;
    end else if (inc_half && (COMPRESSED != 0)) begin
      pc_d = pc_q + c_TWO;
    end
    if (w_load) begin
      pc_d = w_aligned;
    end
  end

  // RAS bookkeeping. Push together with a successful pop swaps the top
  // entry in place (co-routine); otherwise a push lands above the top and
  // a full stack silently overwrites its oldest entry as the pointer wraps.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    w_waddr = ptr_q + c_PTR_W'(1);
    if (push && w_pop_hit) begin
      w_waddr = ptr_q;
    end else if (push) begin
      ptr_d = ptr_q + c_PTR_W'(1);
      if (cnt_q != c_DEPTH) begin
        cnt_d = cnt_q + c_CNT_W'(1);
      end
    end else if (w_pop_hit) begin
      ptr_d = ptr_q - c_PTR_W'(1);
      cnt_d = cnt_q - c_CNT_W'(1);
    end
  end

  // Sticky flags: a new error outranks a clear in the same cycle.
  always_comb begin
    mis_d = mis_q;
    und_d = und_q;
    if (w_misalign) begin
      mis_d = 1'b1;
    end else if (clr_err) begin
      mis_d = 1'b0;
    end
    if (w_underflow) begin
      und_d = 1'b1;
    end else if (clr_err) begin
      und_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      und_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      und_q <= und_d;
      if (push) begin
        ras_q[w_waddr] <= w_link;
      end
    end
  end

  assign bus = rd      ? pc_q   :
               rd_link ? w_link :
                         {XLEN{1'bz}};

  assign pc_out        = pc_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == c_DEPTH);
  assign err_misalign  = mis_q;
  assign err_underflow = und_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Self-checking bench for pc_unit. Stimulus computes the expected
//            observable state from a queue-based reference model and pushes
//            it to a scoreboard; a monitor compares on each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;

  // Strobe bit positions: {clr, pop, push, half, inc, rel, wr, rd_link, rd}
  localparam logic [8:0] S_RD   = 9'h001;
  localparam logic [8:0] S_RL   = 9'h002;
  localparam logic [8:0] S_WR   = 9'h004;
  localparam logic [8:0] S_REL  = 9'h008;
  localparam logic [8:0] S_INC  = 9'h010;
  localparam logic [8:0] S_HALF = 9'h020;
  localparam logic [8:0] S_PUSH = 9'h040;
  localparam logic [8:0] S_POP  = 9'h080;
  localparam logic [8:0] S_CLR  = 9'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd = 0, rd_link = 0, wr = 0, rel = 0, inc = 0, inc_half = 0;
  logic push = 0, pop = 0, clr_err = 0;
  logic            tb_en  = 1'b1;
  logic [XLEN-1:0] tb_val = '0;
  wire  [XLEN-1:0] bus;
  logic [XLEN-1:0] pc_out;
  logic ras_empty, ras_full, err_misalign, err_underflow;

  assign bus = tb_en ? tb_val : {XLEN{1'bz}};

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RV),
    .RAS_DEPTH   (DEPTH),
    .COMPRESSED  (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd           (rd),
    .rd_link      (rd_link),
    .wr           (wr),
    .rel          (rel),
    .inc          (inc),
    .inc_half     (inc_half),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .bus          (bus),
    .pc_out       (pc_out),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .err_misalign (err_misalign),
    .err_underflow(err_underflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] busv;
    logic        empty;
    logic        full;
    logic        mis;
    logic        und;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: the stack is an ordinary queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis, m_und;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RV;
    m_ras.delete();
    m_mis = 1'b0;
    m_und = 1'b0;
  endtask

  // One clock cycle: apply strobes, record what must be visible now, then
  // advance the model across the coming edge.
  task automatic cyc(input logic [8:0] s, input logic [31:0] v);
    exp_t        e;
    logic [31:0] bv, link, t, npc;
    logic        ld, mis, und;
    {clr_err, pop, push, inc_half, inc, rel, wr, rd_link, rd} = s;
    tb_en  = !(s[0] || s[1]);
    tb_val = v;
    link   = m_pc + 32'd4;
    bv     = s[0] ? m_pc : (s[1] ? link : v);

    e.pc    = m_pc;
    e.busv  = bv;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.mis   = m_mis;
    e.und   = m_und;
    sbq.push_back(e);

    und = s[7] && (m_ras.size() == 0);
    ld  = 1'b0;
    t   = '0;
    npc = m_pc;
    if (s[7]) begin
      if (m_ras.size() > 0) begin
        t  = m_ras[$];
        ld = 1'b1;
      end
    end else if (s[2]) begin
      t  = bv;
      ld = 1'b1;
    end else if (s[3]) begin
      t  = m_pc + bv;
      ld = 1'b1;
    end else if (s[4]) begin
      npc = m_pc + 32'd4;
    end
    mis = ld && t[1];
    if (ld) npc = t & ~32'h3;

    if (s[6] && s[7] && m_ras.size() > 0) begin
      m_ras[m_ras.size()-1] = link;
    end else if (s[6]) begin
      m_ras.push_back(link);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (s[7] && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end

    m_pc = npc;
    if (mis) m_mis = 1'b1; else if (s[8]) m_mis = 1'b0;
    if (und) m_und = 1'b1; else if (s[8]) m_und = 1'b0;

    @(posedge clk);
    #1;
  endtask

  // Monitor: the unit's outputs are always valid, so one record per cycle.
  exp_t me;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("pc_out",        pc_out,                me.pc);
      chk("bus",           bus,                   me.busv);
      chk("ras_empty",     {31'd0, ras_empty},     {31'd0, me.empty});
      chk("ras_full",      {31'd0, ras_full},      {31'd0, me.full});
      chk("err_misalign",  {31'd0, err_misalign},  {31'd0, me.mis});
      chk("err_underflow", {31'd0, err_underflow}, {31'd0, me.und});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic rand_phase(input int n);
    logic [8:0]  s;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      s = '0;
      if ($urandom_range(0, 3) == 0) s |= S_RD;
      if ($urandom_range(0, 3) == 0) s |= S_RL;
      if ($urandom_range(0, 4) == 0) s |= S_WR;
      if ($urandom_range(0, 4) == 0) s |= S_REL;
      if ($urandom_range(0, 2) == 0) s |= S_INC;
      if ($urandom_range(0, 3) == 0) s |= S_HALF;
      if ($urandom_range(0, 3) == 0) s |= S_PUSH;
      if ($urandom_range(0, 4) == 0) s |= S_POP;
      if ($urandom_range(0, 7) == 0) s |= S_CLR;
      v = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      cyc(s, v);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, sequential advance, bus drive and release
    cyc('0, 32'h0);
    cyc(S_INC, 32'h0);
    cyc(S_INC, 32'h0);
    cyc(S_INC, 32'h0);
    cyc(S_RD, 32'h0);
    cyc(S_RL, 32'h0);
    cyc('0, 32'h5A5A_A5A5);

    // Absolute, relative, misaligned load, flag clear
    cyc(S_WR, 32'h2000);
    cyc(S_REL, 32'hFFFF_FFF0);
    cyc(S_WR, 32'h3002);
    cyc(S_CLR, 32'h0);
    cyc('0, 32'h0);

    // Call and return
    cyc(S_WR, 32'h40);
    cyc(S_WR | S_PUSH, 32'h800);
    cyc(S_POP, 32'h0);
    cyc('0, 32'h0);

    // Overflow then drain past empty
    cyc(S_WR, 32'h0);
    for (int i = 0; i < 5; i++) cyc(S_PUSH | S_INC, 32'h0);
    for (int i = 0; i < 5; i++) cyc(S_POP | S_INC, 32'h0);
    cyc(S_CLR, 32'h0);

    // Priority, co-routine swap, wrap, rel driven by own rd, ignored inc_half
    cyc(S_INC | S_WR, 32'h500);
    cyc(S_WR, 32'h40);
    cyc(S_PUSH | S_WR, 32'h900);
    cyc(S_PUSH | S_POP, 32'h0);
    cyc(S_POP, 32'h0);
    cyc(S_WR, 32'hFFFF_FFFC);
    cyc(S_INC, 32'h0);
    cyc(S_WR, 32'h1230);
    cyc(S_RD | S_REL, 32'h0);
    cyc(S_HALF, 32'h0);
    cyc(S_POP | S_PUSH, 32'h0);
    cyc('0, 32'h0);

    rand_phase(300);

    // Asynchronous reset between edges while strobes are active
    cyc(S_WR | S_PUSH, 32'h3002);
    {clr_err, pop, push, inc_half, inc, rel, wr, rd_link, rd} = S_WR | S_PUSH;
    tb_en  = 1'b1;
    tb_val = 32'h0000_0777;
    #2 rst = 1'b1;
    #1;
    chk("async pc_out",        pc_out,                  RV);
    chk("async ras_empty",     {31'd0, ras_empty},     32'd1);
    chk("async ras_full",      {31'd0, ras_full},      32'd0);
    chk("async err_misalign",  {31'd0, err_misalign},  32'd0);
    chk("async err_underflow", {31'd0, err_underflow}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset hold pc_out", pc_out, RV);
    {clr_err, pop, push, inc_half, inc, rel, wr, rd_link, rd} = '0;
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    rand_phase(300);
    cyc('0, 32'h0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
